rc6_key_schedule: RTL and testbench

RC6-32/20/32 key expansion stage that sits directly upstream of `RC6encryption`. It accepts a 256-bit user key and runs the standard RC6 mixing loop, one iteration per clock, to produce the 44 round-key words S[0..43]. The words are held in an internal array that the encryption core reads through a registered address/data port once `outKeyValid` is high.

---
 rtl/rc6_pkg.sv | 35 +++
 rtl/rc6_key_schedule_if.sv | 19 +
 rtl/rc6_ks_mix.sv | 19 +
 rtl/rc6_key_schedule.sv | 90 +++++++++
 tb/tb_rc6_key_schedule.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rc6_pkg.sv
// rtl/rc6_pkg.sv - RC6-32/20/32 constants, S_INIT table and rotate helper.
package rc6_pkg;

    localparam logic [31:0] P32       = 32'hB7E15163;
    localparam logic [31:0] Q32       = 32'h9E3779B9;
    localparam int          T_WORDS   = 44;
    localparam int          MIX_ITERS = 132;

    typedef logic [31:0] sInit_t [0:T_WORDS-1];

    function automatic sInit_t buildSInit();
        sInit_t s;
        s[0] = P32;
        for (int k = 1; k < T_WORDS; k++) begin
            s[k] = s[k-1] + Q32;
        end
        return s;
    endfunction

    localparam sInit_t S_INIT = buildSInit();

    // Upper half of {x,x} shifted left is exactly the 32-bit left rotate.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    // Key word m packs key bytes little-endian; byte k sits at key[255-8k -: 8].
    function automatic logic [31:0] keyWord(input logic [255:0] key, input int m);
        return {key[255-8*(4*m+3) -: 8], key[255-8*(4*m+2) -: 8],
                key[255-8*(4*m+1) -: 8], key[255-8*(4*m) -: 8]};
    endfunction

endpackage

// File: rtl/rc6_key_schedule_if.sv
// rtl/rc6_key_schedule_if.sv - key load, status and round-key read port bundle.
interface rc6_key_schedule_if;
    logic         inKeyWr;
    logic [255:0] inKey;
    logic [5:0]   inRkAddr;
    logic [31:0]  outRk;
    logic         outBusy;
    logic         outKeyValid;

    modport master (
        output inKeyWr, inKey, inRkAddr,
        input  outRk, outBusy, outKeyValid
    );

    modport slave (
        input  inKeyWr, inKey, inRkAddr,
        output outRk, outBusy, outKeyValid
    );
endinterface

// File: rtl/rc6_ks_mix.sv
// rtl/rc6_ks_mix.sv - one combinational RC6 key mixing step (A', B').
module rc6_ks_mix
    import rc6_pkg::*;
(
    input  logic [31:0] sI,
    input  logic [31:0] lJ,
    input  logic [31:0] aIn,
    input  logic [31:0] bIn,
    output logic [31:0] aOut,
    output logic [31:0] bOut
);
    logic [31:0] abSum;

    always_comb begin
        aOut  = rotl32(sI + aIn + bIn, 5'd3);
        abSum = aOut + bIn;
        bOut  = rotl32(lJ + abSum, abSum[4:0]);
    end
endmodule

// File: rtl/rc6_key_schedule.sv
// rtl/rc6_key_schedule.sv - RC6 key expansion, one mix iteration per clock.
module rc6_key_schedule
    import rc6_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 20,
    parameter int C = 8
) (
    input  logic inClk,
    input  logic inReset,
    rc6_key_schedule_if.slave ks
);
    localparam int T  = 2 * R + 4;
    localparam int IW = $clog2(T);
    localparam int JW = $clog2(C);
    localparam logic [IW-1:0] I_LAST   = IW'(T - 1);
    localparam logic [7:0]    CNT_LAST = 8'(MIX_ITERS - 1);

    typedef enum logic {IDLE, MIX} state_t;

    state_t        state;
    logic [W-1:0]  sMem [0:T-1];
    logic [W-1:0]  lMem [0:C-1];
    logic [W-1:0]  a, b;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [7:0]    cnt;
    logic [W-1:0]  aNext, bNext;

    rc6_ks_mix uMix (
        .sI   (sMem[i]),
        .lJ   (lMem[j]),
        .aIn  (a),
        .bIn  (b),
        .aOut (aNext),
        .bOut (bNext)
    );

    always_ff @(posedge inClk) begin
        if (inReset) begin
            state          <= IDLE;
            ks.outBusy     <= 1'b0;
            ks.outKeyValid <= 1'b0;
            ks.outRk       <= '0;
            a              <= '0;
            b              <= '0;
            i              <= '0;
            j              <= '0;
            cnt            <= '0;
        end else begin
            // Read port samples pre-edge contents, so it lags a mix write by one cycle.
            ks.outRk <= (ks.inRkAddr < 6'(T)) ? sMem[ks.inRkAddr] : '0;
            case (state)
                IDLE: begin
                    if (ks.inKeyWr) begin
                        for (int m = 0; m < C; m++) begin
                            lMem[m] <= keyWord(ks.inKey, m);
                        end
                        for (int k = 0; k < T; k++) begin
                            sMem[k] <= S_INIT[k];
                        end
                        a              <= '0;
                        b              <= '0;
                        i              <= '0;
                        j              <= '0;
                        cnt            <= '0;
                        ks.outKeyValid <= 1'b0;
                        ks.outBusy     <= 1'b1;
                        state          <= MIX;
                    end
                end
                MIX: begin
                    sMem[i] <= aNext;
                    lMem[j] <= bNext;
                    a       <= aNext;
                    b       <= bNext;
                    i       <= (i == I_LAST) ? '0 : i + 1'b1;
                    j       <= j + 1'b1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        ks.outBusy     <= 1'b0;
                        ks.outKeyValid <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc6_key_schedule.sv
// tb/tb_rc6_key_schedule.sv - randomized bench for rc6_key_schedule against a reference model.
module tb_rc6_key_schedule;
    logic inClk = 1'b0;
    logic inReset;
    int   checks = 0;
    int   errors = 0;
    int   cycles;

    logic [31:0] expS [44];
    logic [31:0] dutS [44];

    always #5 inClk = ~inClk;

    rc6_key_schedule_if ks ();

    rc6_key_schedule #(.W(32), .R(20), .C(8)) dut (
        .inClk   (inClk),
        .inReset (inReset),
        .ks      (ks.slave)
    );

    task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
    endfunction

    task automatic buildModel(input logic [255:0] key);
        logic [31:0] l [8];
        logic [31:0] a, b, sum;
        int ii, jj;
        for (int m = 0; m < 8; m++) l[m] = 0;
        for (int k = 0; k < 32; k++) begin
            logic [31:0] byteVal;
            byteVal = 32'((key >> (248 - 8 * k)) & 256'hFF);
            l[k / 4] = l[k / 4] | (byteVal << (8 * (k % 4)));
        end
        expS[0] = 32'hB7E15163;
        for (int k = 1; k < 44; k++) expS[k] = expS[k-1] + 32'h9E3779B9;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int s = 0; s < 3 * 44; s++) begin
            a = rotl(expS[ii] + a + b, 3);
            expS[ii] = a;
            sum = a + b;
            b = rotl(l[jj] + sum, int'(sum % 32));
            l[jj] = b;
            ii = (ii + 1) % 44;
            jj = (jj + 1) % 8;
        end
    endtask

    task automatic startKey(input logic [255:0] key);
        @(negedge inClk);
        ks.inKeyWr = 1'b1;
        ks.inKey   = key;
        @(negedge inClk);
        ks.inKeyWr = 1'b0;
    endtask

    // Entered just after the accepting edge; stimulus set at count c is seen at mix edge c.
    task automatic runMix(input int strobeAt, input int resetAt, input logic [255:0] otherKey);
        cycles = 0;
        while (ks.outBusy && cycles < 400) begin
            cycles++;
            ks.inKeyWr = (cycles == strobeAt);
            ks.inKey   = (cycles == strobeAt) ? otherKey : ks.inKey;
            inReset    = (cycles == resetAt);
            @(negedge inClk);
        end
        ks.inKeyWr = 1'b0;
        inReset    = 1'b0;
    endtask

    task automatic readAll();
        for (int k = 0; k < 44; k++) begin
            ks.inRkAddr = 6'(k);
            @(negedge inClk);
            dutS[k] = ks.outRk;
        end
    endtask

    task automatic compareAll(input string tag);
        readAll();
        for (int k = 0; k < 44; k++) checkValue($sformatf("%s S[%0d]", tag, k), 128'(dutS[k]), 128'(expS[k]));
    endtask

    task automatic fullSchedule(input string tag, input logic [255:0] key);
        buildModel(key);
        startKey(key);
        checkValue({tag, " busy after accept"}, 128'(ks.outBusy), 128'(1));
        checkValue({tag, " valid after accept"}, 128'(ks.outKeyValid), 128'(0));
        runMix(0, 0, '0);
        checkValue({tag, " busy cycles"}, 128'(cycles), 128'(132));
        checkValue({tag, " valid at end"}, 128'(ks.outKeyValid), 128'(1));
        compareAll(tag);
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] encryptZero();
        logic [31:0] a, b, c, d, t, u, tmp;
        a = 0; b = dutS[0]; c = 0; d = dutS[1];
        for (int r = 1; r <= 20; r++) begin
            t = rotl(b * (2 * b + 1), 5);
            u = rotl(d * (2 * d + 1), 5);
            a = rotl(a ^ t, int'(u[4:0])) + dutS[2*r];
            c = rotl(c ^ u, int'(t[4:0])) + dutS[2*r+1];
            tmp = a; a = b; b = c; c = d; d = tmp;
        end
        a = a + dutS[42];
        c = c + dutS[43];
        return {bswap(a), bswap(b), bswap(c), bswap(d)};
    endfunction

    initial begin
        logic [255:0] keyA, keyB;
        inReset     = 1'b1;
        ks.inKeyWr  = 1'b0;
        ks.inKey    = '0;
        ks.inRkAddr = 6'd50;
        repeat (2) @(negedge inClk);
        checkValue("reset busy", 128'(ks.outBusy), 128'(0));
        checkValue("reset valid", 128'(ks.outKeyValid), 128'(0));
        checkValue("reset rk", 128'(ks.outRk), 128'(0));
        inReset = 1'b0;
        @(negedge inClk);
        checkValue("addr 50 reads zero", 128'(ks.outRk), 128'(0));

        // First iterations with a zero key.
        ks.inRkAddr = 6'd0;
        buildModel('0);
        startKey('0);
        ks.inRkAddr = 6'd1;
        @(negedge inClk);
        checkValue("S_INIT[1] before mix", 128'(ks.outRk), 128'(32'h5618CB1C));
        ks.inRkAddr = 6'd0;
        @(negedge inClk);
        checkValue("S[0] after E1", 128'(ks.outRk), 128'(32'hBF0A8B1D));
        runMix(0, 0, '0);
        checkValue("zero key busy tail", 128'(cycles), 128'(130));
        checkValue("zero key valid", 128'(ks.outKeyValid), 128'(1));
        compareAll("zero key");
        checkValue("zero key ciphertext", encryptZero(), 128'h8f5fbd0510d15fa893fa3fda6e857ec2);

        fullSchedule("key 20..0", 256'h20 << 248);
        fullSchedule("key zero", '0);
        for (int n = 0; n < 2; n++) begin
            keyA = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            fullSchedule($sformatf("random %0d", n), keyA);
        end

        // Strobe during mixing is ignored.
        keyA = {8{$urandom()}};
        keyB = ~keyA;
        buildModel(keyA);
        startKey(keyA);
        runMix(50, 0, keyB);
        checkValue("ignored strobe cycles", 128'(cycles), 128'(132));
        checkValue("ignored strobe valid", 128'(ks.outKeyValid), 128'(1));
        @(negedge inClk);
        checkValue("ignored strobe stays idle", 128'(ks.outBusy), 128'(0));
        compareAll("ignored strobe");

        // Reset in the middle of a mix.
        startKey(keyB);
        runMix(0, 70, '0);
        checkValue("reset mid-mix cycles", 128'(cycles), 128'(70));
        checkValue("reset mid-mix busy", 128'(ks.outBusy), 128'(0));
        checkValue("reset mid-mix valid", 128'(ks.outKeyValid), 128'(0));
        @(negedge inClk);
        checkValue("reset mid-mix still idle", 128'(ks.outBusy), 128'(0));
        fullSchedule("after reset", keyB);

        // Rekey while valid: valid drops on the accepting edge.
        checkValue("valid before rekey", 128'(ks.outKeyValid), 128'(1));
        keyA = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        fullSchedule("rekey", keyA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
